// File: rtl/adder_pkg.sv
// ---------------------------------------------------------------------------
// adder_pkg
//   Types and constants shared by the 6-bit prefix adder and its downstream
//   result buffer.
//   ADD_WIDTH    : sum width produced by the adder (s0..s5)
//   add_result_t : one adder result, {carry-out, sum}
// ---------------------------------------------------------------------------
package adder_pkg;

   localparam int ADD_WIDTH = 6;

   typedef struct packed {
      logic                 carry;
      logic [ADD_WIDTH-1:0] sum;
   } add_result_t;

endpackage : adder_pkg

// File: rtl/adder_result_buffer_if.sv
// ---------------------------------------------------------------------------
// adder_result_buffer_if
//   Valid/ready handshake bundle around the adder result buffer.
//   Upstream side   : in_valid, in_ready, in_sum, in_carry
//   Downstream side : out_valid, out_ready, out_sum, out_carry
//   Modports:
//     slave  - the buffer's view (takes in_*, drives out_* and in_ready)
//     master - the surrounding environment's view (the opposite directions)
// ---------------------------------------------------------------------------
import adder_pkg::*;

interface adder_result_buffer_if #(
   parameter int WIDTH = ADD_WIDTH
);

   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] in_sum;
   logic             in_carry;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] out_sum;
   logic             out_carry;

   modport slave (
      input  in_valid, in_sum, in_carry, out_ready,
      output in_ready, out_valid, out_sum, out_carry
   );

   modport master (
      output in_valid, in_sum, in_carry, out_ready,
      input  in_ready, out_valid, out_sum, out_carry
   );

endinterface : adder_result_buffer_if

// File: rtl/result_fifo.sv
// ---------------------------------------------------------------------------
// result_fifo
//   Generic DEPTH-entry FIFO of add_result_t with registered pointers and
//   occupancy. Storage is cleared on reset so the read port shows zero.
//   Ports:
//     clk, rst  : clock, synchronous active-high reset
//     push      : write wrData (ignored while full)
//     pop       : retire head entry (ignored while empty)
//     wrData    : entry to store
//     rdData    : head entry, zero while empty
//     full      : occupancy == DEPTH
//     empty     : occupancy == 0
// ---------------------------------------------------------------------------
import adder_pkg::*;

module result_fifo #(
   parameter int DEPTH = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        push,
   input  logic        pop,
   input  add_result_t wrData,
   output add_result_t rdData,
   output logic        full,
   output logic        empty
);

   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int OCC_W = PTR_W + 1;

   add_result_t      r_mem [DEPTH];
   logic [PTR_W-1:0] r_wrPtr;
   logic [PTR_W-1:0] r_rdPtr;
   logic [OCC_W-1:0] r_occ;

   logic w_doPush;
   logic w_doPop;

   assign full     = (r_occ == OCC_W'(DEPTH));
   assign empty    = (r_occ == '0);
   assign w_doPush = push & ~full;
   assign w_doPop  = pop & ~empty;

   // Head is read straight from storage; gating with empty keeps old
   // entries from ever showing up on the read port.
   assign rdData = empty ? '0 : r_mem[r_rdPtr];

   // Pointers wrap naturally because DEPTH is a power of two; a push and
   // pop in the same cycle moves both pointers and leaves occupancy alone.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_wrPtr <= '0;
         r_rdPtr <= '0;
         r_occ   <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            r_mem[i] <= '0;
         end
      end else begin
         if (w_doPush) begin
            r_mem[r_wrPtr] <= wrData;
            r_wrPtr        <= r_wrPtr + PTR_W'(1);
         end
         if (w_doPop) begin
            r_rdPtr <= r_rdPtr + PTR_W'(1);
         end
         case ({w_doPush, w_doPop})
            2'b10:   r_occ <= r_occ + OCC_W'(1);
            2'b01:   r_occ <= r_occ - OCC_W'(1);
            default: r_occ <= r_occ;
         endcase
      end
   end

endmodule : result_fifo

// File: rtl/adder_result_buffer.sv
// ---------------------------------------------------------------------------
// adder_result_buffer
//   Captures {carry, sum} results from the prefix adder under valid/ready flow
//   control, buffering them in result_fifo so a stalled consumer never drops
//   data, and keeps a saturating count of accepted carry-out events.
//   Build option: define SAT_CLAMP_EN to store carry results with the sum
//   clamped to all ones; otherwise the wrapped sum is stored as-is.
//   Ports:
//     clk, rst   : clock, synchronous active-high reset
//     bus        : handshake bundle (slave modport), in_* / out_*
//     ovf_clr    : synchronous clear of ovf_count
//     ovf_count  : saturating count of accepted results with carry set
//     full/empty : FIFO status
// ---------------------------------------------------------------------------
import adder_pkg::*;

module adder_result_buffer #(
   parameter int WIDTH = ADD_WIDTH,
   parameter int DEPTH = 2,
   parameter int CNT_W = 8
) (
   input  logic                   clk,
   input  logic                   rst,
   adder_result_buffer_if.slave   bus,
   input  logic                   ovf_clr,
   output logic [CNT_W-1:0]       ovf_count,
   output logic                   full,
   output logic                   empty
);

   logic        w_push;
   logic        w_pop;
   logic        w_carryPush;
   add_result_t w_wrData;
   add_result_t w_rdData;
   logic [CNT_W-1:0] r_ovfCount;

   // Ready depends only on registered occupancy, so a pop in the same cycle
   // cannot open a slot for a push while full.
   assign bus.in_ready  = ~full;
   assign bus.out_valid = ~empty;
   assign w_push        = bus.in_valid & ~full;
   assign w_pop         = ~empty & bus.out_ready;
   assign w_carryPush   = w_push & bus.in_carry;

   // Entry formation: in the clamped build a carry result saturates the sum.
   always_comb begin
      w_wrData.carry = bus.in_carry;
`ifdef SAT_CLAMP_EN
      w_wrData.sum   = bus.in_carry ? {WIDTH{1'b1}} : bus.in_sum;
`else
      w_wrData.sum   = bus.in_sum[WIDTH-1:0];
`endif
   end

   result_fifo #(
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk    (clk),
      .rst    (rst),
      .push   (w_push),
      .pop    (w_pop),
      .wrData (w_wrData),
      .rdData (w_rdData),
      .full   (full),
      .empty  (empty)
   );

   assign bus.out_sum   = w_rdData.sum;
   assign bus.out_carry = w_rdData.carry;

   // Overflow event counter: a clear restarts from zero but still counts a
   // carry push landing on the same edge; otherwise it sticks at all ones.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_ovfCount <= '0;
      end else if (ovf_clr) begin
         r_ovfCount <= CNT_W'(w_carryPush);
      end else if (w_carryPush && (r_ovfCount != '1)) begin
         r_ovfCount <= r_ovfCount + CNT_W'(1);
      end
   end

   assign ovf_count = r_ovfCount;

endmodule : adder_result_buffer
